playfield_mem: RTL and testbench
================================

// Module: playfield_mem
// PURPOSE
//  Board storage feeding the block renderer: holds one 3-bit block type per playfield cell.
//  The renderer drives the row/column select each pixel; this block returns that cell's type combinationally.
//  Game logic writes cells one at a time through a write port.
//  A built-in line-clear engine removes full rows and drops the rows above them.
// PARAMETERS
//  ROWS     12  vertical cell count; rows 0 (top) .. ROWS-1 (bottom)
//  COLS     21  horizontal cell count; columns 0 .. COLS-1
//  BT_W     3   block-type width; value 0 = empty
//  TOTAL_W  10  width of the lifetime cleared-lines counter
// PORTS
//  clk_25_175     in   1      pixel clock; only clock
//  reset          in   1      asynchronous, active-high
//  rd_v           in   5      row select from renderer (memselector_v)
//  rd_h           in   5      column select from renderer (memselector_h)
//  rd_blktype     out  BT_W   type of cell (rd_v,rd_h); combinational; 0 if out of range
//  wr_en          in   1      write request, single cycle
//  wr_v           in   5      write row
//  wr_h           in   5      write column
//  wr_blktype     in   BT_W   value to write (0 erases)
//  clear_start    in   1      pulse: run one line-clear pass
//  busy           out  1      line-clear engine active
//  clear_done     out  1      one-cycle pulse at end of a pass
//  lines_cleared  out  3      rows removed by the last pass; saturates at 7
//  total_lines    out  TOTAL_W  rows removed since reset; saturates at all-ones
// BEHAVIOUR
//  Reset (async): all cells 0; FSM IDLE; busy, clear_done, lines_cleared, total_lines = 0.
//  Read: pure combinational, zero latency. It reflects the array continuously, including during a pass (intermediate frames are acceptable).
//  Write: committed at the clock edge when wr_en=1, busy=0 and wr_v<ROWS and wr_h<COLS.
//   Otherwise it is silently dropped.
//  Storage: ROWS registers of COLS*BT_W bits each, so a whole row can be copied in one cycle.
//  FSM states:
//   IDLE:  clear_start && !busy -> SCAN with r=ROWS-1 and pass counter = 0.
//          wr_en in the same cycle is still applied.
//          clear_start while busy is ignored.
//   SCAN:  one row per cycle.
//          If row r is full (every cell !=0): increment the pass counter and total_lines (both saturating); set s=r; go to SHIFT.
//          Else if r==0: go to DONE.
//          Else r <= r-1.
//   SHIFT: each cycle, if s>0 then row[s] <= row[s-1] and s <= s-1.
//          If s==0: row[0] <= 0 and return to SCAN at the same r, which is re-checked.
//   DONE:  for one cycle: clear_done=1 and lines_cleared <= pass counter; then IDLE.
//  busy = (state != IDLE). It rises the cycle after clear_start is sampled.
//  Timing:
//   - Empty or no-full board: busy for ROWS+1 cycles; clear_done in the last of them.
//   - Each full row at index r adds r+2 cycles (1 scan + r+1 shift).
//  lines_cleared holds its value until the next DONE. total_lines never wraps.
//  Reset asserted mid-pass: immediate return to the reset state.
//   The partially shifted board is discarded (all cells are cleared).
// STRUCTURE
//  Shared package tetris_pkg:
//   - BT_W, BLK_EMPTY=0, default ROWS/COLS
//   - FSM state encoding (IDLE, SCAN, SHIFT, DONE)
//   - the 5-bit coordinate width
//  The renderer and color LUT use the same package.
//  Sub-module row_full_detect: combinational. Input is one COLS*BT_W row; output is 1 when every cell is nonzero.
//  Instantiated once, on row[r].
// TESTING
//  1 Reset, then read all (v,h) -> every rd_blktype=0; rd_v=12 or rd_h=21 -> 0.
//  2 Write (3,5)=6, then read (3,5) -> 6 the same cycle after the edge.
//    Write (12,0)=5 -> dropped; the array is unchanged.
//  3 Empty board, clear_start -> busy high 13 cycles; clear_done on the 13th; lines_cleared=0.
//  4 Fill row 11 with 1, put 2 at (10,4), clear_start ->
//    after done: row 11 all 0 except (11,4)=2; lines_cleared=1; total_lines=1; busy 13+13=26 cycles.
//  5 Rows 10 and 11 full, 7 at (9,0) -> after pass: (11,0)=7, rest empty; lines_cleared=2.
//    Write and clear_start issued during busy -> ignored.
//  6 Assert reset midway through SHIFT -> all cells 0, busy=0, total_lines=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared playfield definitions used by the board memory, renderer and colour LUT.
package tetris_pkg;

   localparam int unsigned BT_W     = 3;
   localparam int unsigned COORD_W  = 5;
   localparam int unsigned ROWS_DEF = 12;
   localparam int unsigned COLS_DEF = 21;

   localparam logic [BT_W-1:0] BLK_EMPTY = '0;

   // Line-clear engine state encoding
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SCAN  = 2'd1;
   localparam logic [1:0] ST_SHIFT = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/row_full_detect.sv
// Flags a playfield row in which every cell holds a non-empty block type.
module row_full_detect
   import tetris_pkg::*;
#(
   parameter int unsigned COLS = COLS_DEF
) (
   input  logic [COLS*BT_W-1:0] row_i,
   output logic                 full_c_o
);

   always_comb begin
      full_c_o = 1'b1;
      for (int c = 0; c < int'(COLS); c++) begin
         if (row_i[c*BT_W +: BT_W] == BLK_EMPTY) begin
            full_c_o = 1'b0;
         end
      end
   end

endmodule

// File: rtl/playfield_mem.sv
// Playfield cell storage with a combinational renderer read port, a single-cell
// write port and a line-clear engine that removes full rows one row per cycle.
module playfield_mem
   import tetris_pkg::*;
#(
   parameter int unsigned ROWS    = ROWS_DEF,
   parameter int unsigned COLS    = COLS_DEF,
   parameter int unsigned TOTAL_W = 10
) (
   input  logic               clk_25_175,
   input  logic               reset,
   input  logic [COORD_W-1:0] rd_v,
   input  logic [COORD_W-1:0] rd_h,
   output logic [BT_W-1:0]    rd_blktype,
   input  logic               wr_en,
   input  logic [COORD_W-1:0] wr_v,
   input  logic [COORD_W-1:0] wr_h,
   input  logic [BT_W-1:0]    wr_blktype,
   input  logic               clear_start,
   output logic               busy,
   output logic               clear_done,
   output logic [2:0]         lines_cleared,
   output logic [TOTAL_W-1:0] total_lines
);

   localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;
   localparam logic [COORD_W-1:0] ROWS_C = COORD_W'(ROWS);
   localparam logic [COORD_W-1:0] COLS_C = COORD_W'(COLS);

   typedef logic [COLS-1:0][BT_W-1:0] row_t;

   row_t               rows_q [ROWS];
   row_t               rows_d [ROWS];
   logic [1:0]         state_q, state_d;
   logic [RW-1:0]      r_q, r_d;
   logic [RW-1:0]      s_q, s_d;
   logic [2:0]         cnt_q, cnt_d;
   logic [2:0]         lines_q, lines_d;
   logic [TOTAL_W-1:0] total_q, total_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               row_full;
   logic               wr_ok;

   row_full_detect #(
      .COLS (COLS)
   ) u_row_full (
      .row_i    (rows_q[r_q]),
      .full_c_o (row_full)
   );

   // Renderer read: out-of-range coordinates read as empty
   always_comb begin
      rd_blktype = BLK_EMPTY;
      if ((rd_v < ROWS_C) && (rd_h < COLS_C)) begin
         rd_blktype = rows_q[rd_v[RW-1:0]][rd_h[CW-1:0]];
      end
   end

   assign wr_ok = wr_en && (wr_v < ROWS_C) && (wr_h < COLS_C);

   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      s_d     = s_q;
      cnt_d   = cnt_q;
      lines_d = lines_q;
      total_d = total_q;
      rows_d  = rows_q;

      case (state_q)
         ST_IDLE: begin
            if (wr_ok) begin
               rows_d[wr_v[RW-1:0]][wr_h[CW-1:0]] = wr_blktype;
            end
            if (clear_start) begin
               state_d = ST_SCAN;
               r_d     = RW'(ROWS - 1);
               cnt_d   = '0;
            end
         end
         ST_SCAN: begin
            if (row_full) begin
               if (cnt_q != 3'd7) cnt_d = cnt_q + 3'd1;
               if (total_q != '1) total_d = total_q + TOTAL_W'(1);
               s_d     = r_q;
               state_d = ST_SHIFT;
            end else if (r_q == '0) begin
               state_d = ST_DONE;
            end else begin
               r_d = r_q - RW'(1);
            end
         end
         ST_SHIFT: begin
            // Drop everything above the removed row by one, top row refills empty
            if (s_q != '0) begin
               rows_d[s_q] = rows_q[s_q - RW'(1)];
               s_d         = s_q - RW'(1);
            end else begin
               rows_d[0] = '0;
               state_d   = ST_SCAN;
            end
         end
         ST_DONE: begin
            lines_d = cnt_q;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk_25_175 or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         r_q     <= '0;
         s_q     <= '0;
         cnt_q   <= '0;
         lines_q <= '0;
         total_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         for (int i = 0; i < int'(ROWS); i++) begin
            rows_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         s_q     <= s_d;
         cnt_q   <= cnt_d;
         lines_q <= lines_d;
         total_q <= total_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         for (int i = 0; i < int'(ROWS); i++) begin
            rows_q[i] <= rows_d[i];
         end
      end
   end

   assign busy          = busy_q;
   assign clear_done    = done_q;
   assign lines_cleared = lines_q;
   assign total_lines   = total_q;

endmodule

// File: tb/tb_playfield_mem.sv
// Randomized scoreboard bench for playfield_mem against a gravity-compaction board model.
module tb_playfield_mem;

   localparam int ROWS = 12;
   localparam int COLS = 21;
   localparam int TMAX = 1023;

   logic       clk_25_175 = 1'b0;
   logic       reset = 1'b1;
   logic [4:0] rd_v = '0;
   logic [4:0] rd_h = '0;
   logic [2:0] rd_blktype;
   logic       wr_en = 1'b0;
   logic [4:0] wr_v = '0;
   logic [4:0] wr_h = '0;
   logic [2:0] wr_blktype = '0;
   logic       clear_start = 1'b0;
   logic       busy;
   logic       clear_done;
   logic [2:0] lines_cleared;
   logic [9:0] total_lines;

   always #50 clk_25_175 = ~clk_25_175;

   playfield_mem dut (
      .clk_25_175    (clk_25_175),
      .reset         (reset),
      .rd_v          (rd_v),
      .rd_h          (rd_h),
      .rd_blktype    (rd_blktype),
      .wr_en         (wr_en),
      .wr_v          (wr_v),
      .wr_h          (wr_h),
      .wr_blktype    (wr_blktype),
      .clear_start   (clear_start),
      .busy          (busy),
      .clear_done    (clear_done),
      .lines_cleared (lines_cleared),
      .total_lines   (total_lines)
   );

   typedef struct {
      int cycles;
      int lines;
      int total;
   } exp_t;

   exp_t exp_q[$];
   int   board [ROWS][COLS];
   int   total_m  = 0;
   int   errors   = 0;
   int   checks   = 0;
   int   busy_cnt = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: pops the expected pass result whenever the DUT signals clear_done
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk_25_175);
         if (reset) begin
            busy_cnt = 0;
         end else begin
            if (busy) busy_cnt++;
            if (clear_done) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_clear_done", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  chk("busy_cycles", busy_cnt, e.cycles);
                  busy_cnt = 0;
                  @(negedge clk_25_175);
                  chk("lines_cleared", int'(lines_cleared), e.lines);
                  chk("total_lines", int'(total_lines), e.total);
                  chk("busy_after_done", int'(busy), 0);
               end
            end
         end
      end
   end

   // Reference: remove full rows, let the rest fall to the bottom in order
   function automatic void model_clear(output int cyc, output int k);
      int nb [ROWS][COLS];
      int dst;
      bit full;
      cyc = ROWS + 1;
      k   = 0;
      dst = ROWS - 1;
      for (int v = 0; v < ROWS; v++)
         for (int h = 0; h < COLS; h++) nb[v][h] = 0;
      for (int r = ROWS - 1; r >= 0; r--) begin
         full = 1'b1;
         for (int h = 0; h < COLS; h++) if (board[r][h] == 0) full = 1'b0;
         if (full) begin
            cyc += r + k + 2;
            k++;
         end else begin
            for (int h = 0; h < COLS; h++) nb[dst][h] = board[r][h];
            dst--;
         end
      end
      board = nb;
   endfunction

   task automatic do_write(input int v, input int h, input int b);
      @(negedge clk_25_175);
      wr_en      = 1'b1;
      wr_v       = 5'(v);
      wr_h       = 5'(h);
      wr_blktype = 3'(b);
      @(negedge clk_25_175);
      wr_en = 1'b0;
      if (v < ROWS && h < COLS) board[v][h] = b;
   endtask

   task automatic set_cell(input int v, input int h, input int b);
      if (board[v][h] != b) do_write(v, h, b);
   endtask

   task automatic check_board(input string tag);
      for (int v = 0; v < ROWS; v++) begin
         @(negedge clk_25_175);
         for (int h = 0; h < COLS; h++) begin
            rd_v = 5'(v);
            rd_h = 5'(h);
            #1;
            chk($sformatf("%s_rd(%0d,%0d)", tag, v, h), int'(rd_blktype), board[v][h]);
         end
         rd_v = 5'(ROWS + (v % 3) * 9);
         rd_h = 5'(v);
         #1;
         chk($sformatf("%s_rd_oor_v(%0d)", tag, int'(rd_v)), int'(rd_blktype), 0);
         rd_v = 5'(v);
         rd_h = 5'(COLS + (v % 2) * 10);
         #1;
         chk($sformatf("%s_rd_oor_h(%0d)", tag, int'(rd_h)), int'(rd_blktype), 0);
      end
   endtask

   task automatic run_pass(input bit noise, input bit wr_with_start,
                           input int wv, input int wh, input int wb);
      exp_t e;
      int   cyc;
      int   k;
      bit   done;
      @(negedge clk_25_175);
      clear_start = 1'b1;
      if (wr_with_start) begin
         wr_en      = 1'b1;
         wr_v       = 5'(wv);
         wr_h       = 5'(wh);
         wr_blktype = 3'(wb);
         if (wv < ROWS && wh < COLS) board[wv][wh] = wb;
      end
      model_clear(cyc, k);
      total_m  = (total_m + k > TMAX) ? TMAX : total_m + k;
      e.cycles = cyc;
      e.lines  = (k > 7) ? 7 : k;
      e.total  = total_m;
      exp_q.push_back(e);
      done = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk_25_175);
         clear_start = 1'b0;
         wr_en       = 1'b0;
         if (!busy) begin
            done = 1'b1;
            break;
         end
         if (noise) begin
            clear_start = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1) begin
               wr_en      = 1'b1;
               wr_v       = 5'($urandom_range(0, ROWS - 1));
               wr_h       = 5'($urandom_range(0, COLS - 1));
               wr_blktype = 3'($urandom_range(1, 7));
            end
         end
      end
      if (!done) chk("pass_timeout", 0, 1);
   endtask

   task automatic fill_row(input int v, input int b);
      for (int h = 0; h < COLS; h++) set_cell(v, h, b);
   endtask

   initial begin : stimulus
      int mode;
      int hole;
      for (int v = 0; v < ROWS; v++)
         for (int h = 0; h < COLS; h++) board[v][h] = 0;

      repeat (3) @(negedge clk_25_175);
      chk("reset_busy", int'(busy), 0);
      chk("reset_clear_done", int'(clear_done), 0);
      chk("reset_lines", int'(lines_cleared), 0);
      chk("reset_total", int'(total_lines), 0);
      reset = 1'b0;
      check_board("reset");

      // Single write visible right after its edge; out-of-range write dropped
      @(negedge clk_25_175);
      wr_en = 1'b1; wr_v = 5'd3; wr_h = 5'd5; wr_blktype = 3'd6;
      rd_v = 5'd3; rd_h = 5'd5;
      #1 chk("rd_before_write_edge", int'(rd_blktype), 0);
      @(posedge clk_25_175);
      #1 chk("rd_after_write_edge", int'(rd_blktype), 6);
      board[3][5] = 6;
      @(negedge clk_25_175);
      wr_en = 1'b0;
      do_write(12, 0, 5);
      do_write(0, 21, 5);
      check_board("write");
      set_cell(3, 5, 0);

      // Empty board pass
      run_pass(1'b0, 1'b0, 0, 0, 0);
      check_board("empty_pass");

      // One full bottom row with a block above it
      fill_row(11, 1);
      set_cell(10, 4, 2);
      run_pass(1'b0, 1'b0, 0, 0, 0);
      check_board("one_row");

      // Two full rows, traffic during the pass is ignored
      fill_row(10, 3);
      fill_row(11, 5);
      set_cell(11, 4, 5);
      set_cell(9, 0, 7);
      run_pass(1'b1, 1'b0, 0, 0, 0);
      check_board("two_rows");

      // Eight full rows saturate lines_cleared at 7
      for (int v = 4; v < ROWS; v++) fill_row(v, (v % 7) + 1);
      set_cell(3, 20, 4);
      run_pass(1'b0, 1'b0, 0, 0, 0);
      check_board("eight_rows");

      // Randomized boards with noise and a write alongside clear_start
      for (int round = 0; round < 8; round++) begin
         for (int v = 0; v < ROWS; v++) begin
            mode = $urandom_range(0, 3);
            hole = $urandom_range(0, COLS - 1);
            for (int h = 0; h < COLS; h++) begin
               if (mode == 0)      set_cell(v, h, $urandom_range(1, 7));
               else if (mode == 1) set_cell(v, h, (h == hole) ? 0 : $urandom_range(1, 7));
               else                set_cell(v, h, ($urandom_range(0, 1) == 1) ? $urandom_range(1, 7) : 0);
            end
         end
         do_write($urandom_range(12, 31), $urandom_range(0, 31), 3);
         do_write($urandom_range(0, 31), $urandom_range(21, 31), 3);
         run_pass(1'b1, $urandom_range(0, 1) == 1, $urandom_range(0, ROWS - 1),
                  $urandom_range(0, COLS - 1), $urandom_range(0, 7));
         check_board($sformatf("rand%0d", round));
      end

      // Reset in the middle of SHIFT clears everything without a clock edge
      for (int v = 0; v < ROWS; v++) fill_row(v, 0);
      fill_row(11, 2);
      set_cell(0, 0, 5);
      @(negedge clk_25_175);
      clear_start = 1'b1;
      @(negedge clk_25_175);
      clear_start = 1'b0;
      repeat (4) @(negedge clk_25_175);
      chk("busy_mid_shift", int'(busy), 1);
      rd_v = 5'd0; rd_h = 5'd0;
      #1 chk("rd_mid_shift", int'(rd_blktype), 5);
      #1 reset = 1'b1;
      #1;
      chk("async_rst_busy", int'(busy), 0);
      chk("async_rst_total", int'(total_lines), 0);
      chk("async_rst_lines", int'(lines_cleared), 0);
      chk("async_rst_done", int'(clear_done), 0);
      chk("async_rst_rd", int'(rd_blktype), 0);
      for (int v = 0; v < ROWS; v++)
         for (int h = 0; h < COLS; h++) board[v][h] = 0;
      total_m = 0;
      @(negedge clk_25_175);
      @(negedge clk_25_175);
      reset = 1'b0;
      check_board("after_reset");

      // Counter restarts from zero after reset
      fill_row(11, 6);
      run_pass(1'b0, 1'b0, 0, 0, 0);
      check_board("post_reset_pass");

      repeat (3) @(negedge clk_25_175);
      chk("pending_passes", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
